// File: rtl/counter_cmd_pkg.sv
// Shared command/state types for the counter command arbiter.
package counter_cmd_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 3'd0,
    CMD_UP     = 3'd1,
    CMD_DOWN   = 3'd2,
    CMD_CLEAR  = 3'd3,
    CMD_NEGATE = 3'd4,
    CMD_LOAD   = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/counter_cmd_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot winner among requesters, pointer advances on accepted grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_winner
);

  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_win_idx;
  logic [IdxW-1:0] w_idx;

  // Scan farthest offset first so the nearest requester after the pointer overwrites the rest.
  always_comb begin
    o_winner  = '0;
    w_win_idx = r_ptr;
    w_idx     = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IdxW'((int'(r_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_winner        = '0;
        o_winner[w_idx] = 1'b1;
        w_win_idx       = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= IdxW'(N - 1);
    end else if (i_advance) begin
      r_ptr <= w_win_idx;
    end
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shares one Size-bit data counter between NumReq command sources with round-robin grants.
// Define COUNTER_CMD_ARB_SATURATE_EN to clamp UP/DOWN/NEGATE at the range limits instead of wrapping.
//
// state | meaning
// IDLE  | waiting for any request; latches winner's command and pulses its grant
// EXEC  | applies the latched command to the data register
// GAP   | enforced idle spacing after a command, requests ignored
module counter_cmd_arbiter
  import counter_cmd_pkg::*;
#(
  parameter int    NumReq    = 2,
  parameter int    Size      = 4,
  parameter string Signed    = "No",
  parameter int    GapCycles = 0
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic [NumReq-1:0]            i_req,
  input  logic [NumReq-1:0][CMD_W-1:0] i_cmd,
  input  logic [NumReq-1:0][Size-1:0]  i_load_val,
  output logic [NumReq-1:0]            o_grant,
  output logic                         o_busy,
  output logic [Size-1:0]              o_data,
  output logic                         o_overflow
);

  localparam bit IsSigned = (Signed == "Yes");
`ifdef COUNTER_CMD_ARB_SATURATE_EN
  localparam bit Saturate = 1'b1;
`else
  localparam bit Saturate = 1'b0;
`endif
  localparam logic [Size-1:0] MinVal = IsSigned ? {1'b1, {(Size-1){1'b0}}} : {Size{1'b0}};
  localparam logic [Size-1:0] MaxVal = IsSigned ? {1'b0, {(Size-1){1'b1}}} : {Size{1'b1}};
  localparam logic [15:0]     GapLoad = (GapCycles > 0) ? 16'(GapCycles - 1) : 16'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_latch;
  logic              w_exec;
  logic              w_gap_load;
  logic [NumReq-1:0] w_winner;
  logic [CMD_W-1:0]  w_sel_cmd;
  logic [Size-1:0]   w_sel_load;
  logic [CMD_W-1:0]  r_cmd;
  logic [Size-1:0]   r_load_val;
  logic [Size-1:0]   r_data;
  logic [Size-1:0]   w_data_nxt;
  logic              w_ovf_nxt;
  logic              r_ovf;
  logic [NumReq-1:0] r_grant;
  logic [15:0]       r_gap_cnt;

  rr_arbiter #(.N(NumReq)) u_rr_arbiter (
    .i_clk     (i_clock),
    .i_rst_n   (i_reset_n),
    .i_req     (i_req),
    .i_advance (w_latch),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_sel_cmd  = '0;
    w_sel_load = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_winner[i]) begin
        w_sel_cmd  |= i_cmd[i];
        w_sel_load |= i_load_val[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_exec      = 1'b0;
    w_gap_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_latch     = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_exec = 1'b1;
        if (GapCycles == 0) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GAP;
          w_gap_load  = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == 16'd0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wrap lands on the opposite limit; saturation holds at the limit being crossed.
  always_comb begin
    w_data_nxt = r_data;
    w_ovf_nxt  = 1'b0;
    case (r_cmd)
      CMD_UP: begin
        if (r_data == MaxVal) begin
          w_ovf_nxt  = 1'b1;
          w_data_nxt = Saturate ? MaxVal : MinVal;
        end else begin
          w_data_nxt = r_data + Size'(1);
        end
      end
      CMD_DOWN: begin
        if (r_data == MinVal) begin
          w_ovf_nxt  = 1'b1;
          w_data_nxt = Saturate ? MinVal : MaxVal;
        end else begin
          w_data_nxt = r_data - Size'(1);
        end
      end
      CMD_CLEAR: w_data_nxt = '0;
      CMD_NEGATE: begin
        if (IsSigned) begin
          if (r_data == MinVal) begin
            w_ovf_nxt  = 1'b1;
            w_data_nxt = Saturate ? MaxVal : MinVal;
          end else begin
            w_data_nxt = '0 - r_data;
          end
        end
      end
      CMD_LOAD: w_data_nxt = r_load_val;
      default:  w_data_nxt = r_data;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data     <= '0;
      r_grant    <= '0;
      r_ovf      <= 1'b0;
      r_cmd      <= '0;
      r_load_val <= '0;
      r_gap_cnt  <= 16'd0;
    end else begin
      r_grant <= w_latch ? w_winner : '0;
      r_ovf   <= w_exec & w_ovf_nxt;
      if (w_latch) begin
        r_cmd      <= w_sel_cmd;
        r_load_val <= w_sel_load;
      end
      if (w_exec) r_data <= w_data_nxt;
      if (w_gap_load) begin
        r_gap_cnt <= GapLoad;
      end else if (r_state == GAP && r_gap_cnt != 16'd0) begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_busy     = (r_state != IDLE);
  assign o_data     = r_data;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench: unsigned, signed and gapped instances of counter_cmd_arbiter with hand-computed expectations.
module tb_counter_cmd_arbiter;
  import counter_cmd_pkg::*;

`ifdef COUNTER_CMD_ARB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n [3];
  logic [2:0]       req   [3];
  logic [2:0][2:0]  cmd   [3];
  logic [2:0][3:0]  ld    [3];
  logic [2:0]       grant [3];
  logic             busy  [3];
  logic [3:0]       data  [3];
  logic             ovf   [3];

  int n_cmp = 0;
  int n_err = 0;
  int gc [4];
  int ng;
  int nbusy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_cmd_arbiter #(.NumReq(3), .Size(4), .Signed("No"), .GapCycles(0)) u_dut_u (
    .i_clock(clk), .i_reset_n(rst_n[0]), .i_req(req[0]), .i_cmd(cmd[0]), .i_load_val(ld[0]),
    .o_grant(grant[0]), .o_busy(busy[0]), .o_data(data[0]), .o_overflow(ovf[0]));

  counter_cmd_arbiter #(.NumReq(3), .Size(4), .Signed("Yes"), .GapCycles(0)) u_dut_s (
    .i_clock(clk), .i_reset_n(rst_n[1]), .i_req(req[1]), .i_cmd(cmd[1]), .i_load_val(ld[1]),
    .o_grant(grant[1]), .o_busy(busy[1]), .o_data(data[1]), .o_overflow(ovf[1]));

  counter_cmd_arbiter #(.NumReq(3), .Size(4), .Signed("No"), .GapCycles(5)) u_dut_g (
    .i_clock(clk), .i_reset_n(rst_n[2]), .i_req(req[2]), .i_cmd(cmd[2]), .i_load_val(ld[2]),
    .o_grant(grant[2]), .o_busy(busy[2]), .o_data(data[2]), .o_overflow(ovf[2]));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // One command from source s on instance inst; checks grant, resulting data/overflow, return to idle.
  task automatic do_cmd(input int inst, input int s, input logic [2:0] c, input logic [3:0] v,
                        input logic [3:0] exp_d, input logic exp_o, input string tag);
    int n;
    @(negedge clk);
    req[inst]    = 3'b000;
    req[inst][s] = 1'b1;
    cmd[inst][s] = c;
    ld[inst][s]  = v;
    @(negedge clk);
    check_val({tag, "_gnt"}, 32'(grant[inst]), 32'(1) << s);
    req[inst] = 3'b000;
    @(negedge clk);
    check_val({tag, "_data"}, 32'(data[inst]), 32'(exp_d));
    check_val({tag, "_ovf"}, 32'(ovf[inst]), 32'(exp_o));
    check_val({tag, "_gnt_off"}, 32'(grant[inst]), 32'd0);
    n = 0;
    while (busy[inst] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_idle"}, 32'(busy[inst]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      req[i]   = '0;
      cmd[i]   = '0;
      ld[i]    = '0;
    end
    repeat (2) @(negedge clk);
    check_val("rst_data", 32'(data[0]), 32'd0);
    check_val("rst_grant", 32'(grant[0]), 32'd0);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_ovf", 32'(ovf[0]), 32'd0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // unsigned wrap / clamp and no-op commands
    do_cmd(0, 0, CMD_LOAD, 4'd15, 4'd15, 1'b0, "u_load15");
    do_cmd(0, 0, CMD_UP, 4'd0, SAT ? 4'd15 : 4'd0, 1'b1, "u_up_max");
    do_cmd(0, 0, CMD_LOAD, 4'd0, 4'd0, 1'b0, "u_load0");
    do_cmd(0, 0, CMD_DOWN, 4'd0, SAT ? 4'd0 : 4'd15, 1'b1, "u_down_min");
    do_cmd(0, 0, CMD_LOAD, 4'd7, 4'd7, 1'b0, "u_load7");
    do_cmd(0, 0, CMD_UP, 4'd0, 4'd8, 1'b0, "u_up");
    do_cmd(0, 0, CMD_DOWN, 4'd0, 4'd7, 1'b0, "u_down");
    do_cmd(0, 1, CMD_NEGATE, 4'd0, 4'd7, 1'b0, "u_negate");
    do_cmd(0, 1, 3'd6, 4'd5, 4'd7, 1'b0, "u_cmd6");
    do_cmd(0, 1, 3'd7, 4'd5, 4'd7, 1'b0, "u_cmd7");
    do_cmd(0, 2, CMD_CLEAR, 4'd0, 4'd0, 1'b0, "u_clear");

    // all three held with UP: pointer sits at source 2, so order is 0,1,2,0
    @(negedge clk);
    req[0] = 3'b111;
    for (int s = 0; s < 3; s++) cmd[0][s] = CMD_UP;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val($sformatf("rr_gnt%0d", k), 32'(grant[0]), 32'(1) << (k % 3));
      @(negedge clk);
      check_val($sformatf("rr_data%0d", k), 32'(data[0]), 32'(k + 1));
    end
    req[0] = 3'b000;

    // signed wrap / clamp and negate
    do_cmd(1, 0, CMD_LOAD, 4'b1000, 4'b1000, 1'b0, "s_load_min");
    do_cmd(1, 0, CMD_NEGATE, 4'd0, SAT ? 4'b0111 : 4'b1000, 1'b1, "s_neg_min");
    do_cmd(1, 1, CMD_LOAD, 4'd7, 4'd7, 1'b0, "s_load_max");
    do_cmd(1, 1, CMD_UP, 4'd0, SAT ? 4'd7 : 4'd8, 1'b1, "s_up_max");
    do_cmd(1, 2, CMD_LOAD, 4'd8, 4'd8, 1'b0, "s_load8");
    do_cmd(1, 2, CMD_DOWN, 4'd0, SAT ? 4'd8 : 4'd7, 1'b1, "s_down_min");
    do_cmd(1, 0, CMD_LOAD, 4'd3, 4'd3, 1'b0, "s_load3");
    do_cmd(1, 0, CMD_NEGATE, 4'd0, 4'd13, 1'b0, "s_neg3");
    do_cmd(1, 0, CMD_NEGATE, 4'd0, 4'd3, 1'b0, "s_neg_m3");

    // gapped instance: held request gives grants 7 cycles apart, busy 6 of 7
    for (int i = 0; i < 4; i++) gc[i] = 0;
    ng = 0;
    nbusy = 0;
    @(negedge clk);
    req[2] = 3'b001;
    cmd[2][0] = CMD_UP;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (grant[2] != 3'b000 && ng < 4) begin
        gc[ng] = i;
        ng++;
      end
      if (ng >= 1 && i < gc[0] + 7 && busy[2]) nbusy++;
    end
    check_val("gap_first", 32'(gc[0]), 32'd1);
    check_val("gap_period1", 32'(gc[1] - gc[0]), 32'd7);
    check_val("gap_period2", 32'(gc[2] - gc[1]), 32'd7);
    check_val("gap_busy", 32'(nbusy), 32'd6);
    check_val("gap_data", 32'(data[2]), 32'd4);
    check_val("gap_in_gap", 32'(busy[2]), 32'd1);

    // async reset while in GAP
    req[2] = 3'b000;
    #2 rst_n[2] = 1'b0;
    #1;
    check_val("rstgap_data", 32'(data[2]), 32'd0);
    check_val("rstgap_busy", 32'(busy[2]), 32'd0);
    check_val("rstgap_grant", 32'(grant[2]), 32'd0);
    check_val("rstgap_ovf", 32'(ovf[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    do_cmd(2, 1, CMD_UP, 4'd0, 4'd1, 1'b0, "g_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
